aap_load_store_unit: RTL and testbench
======================================

Name: aap_load_store_unit

Overview:
- Initiator side of the data-memory byte-port interface.
- Accepts one 8/16/32-bit load or store request from the execute stage over a valid/ready handshake.
- Splits each request into byte accesses on two read and two write byte ports of the data memory, two bytes per cycle.
- Returns load data (zero- or sign-extended) or store completion over a valid/ready response channel.

Parameters:
- ADDR_W, 9, byte-address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, request/response data width; fixed at 32, not to be overridden.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend loads (ignored for stores and words).
- req_addr  in  ADDR_W  byte address of the lowest byte.
- req_wdata  in  32  store data; low bytes used for byte/half.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request rejected, no memory access made.
- mem_rd1, mem_rd2  out  ADDR_W  byte read addresses.
- mem_rd1_out, mem_rd2_out  in  8  combinational read data for mem_rd1/mem_rd2.
- mem_wr1, mem_wr2  out  ADDR_W  byte write addresses.
- mem_wr1_data, mem_wr2_data  out  8  write bytes.
- mem_wr1_enable, mem_wr2_enable  out  1  write strobes, sampled by the memory on the clock edge.

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP.
- Reset (async) enters IDLE and clears all registers.
- Reset output values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; all mem addresses 0; all write data 0; all write enables 0.

IDLE:
- req_ready=1.
- On req_valid && req_ready: latch addr, size, write, signed and wdata.
- size 11 → go to RESP with err=1.
- Otherwise → go to BEAT0.

BEAT0:
- mem_rd1/mem_wr1 = A.
- mem_rd2/mem_wr2 = A+1 (wraps modulo 2^ADDR_W).
- Store: wr1_enable=1; wr2_enable=1 only for half/word; data = wdata[7:0] and wdata[15:8].
- Load: at the clock edge, capture rd1_out into byte0 and rd2_out into byte1.
- Next state: word → BEAT1; otherwise → RESP.

BEAT1 (word only):
- Addresses A+2 and A+3 (each wraps).
- Store bytes wdata[23:16] and wdata[31:24].
- Load captures into byte2 and byte3.
- Next state → RESP.

RESP:
- resp_valid=1; resp_rdata and resp_err held stable.
- req_ready=0.
- On resp_ready → IDLE; resp_valid drops the next cycle.
- No new request is accepted in the same cycle as the response handshake.

General rules:
- Byte order is little-endian.
- Load extension: byte uses bit 7; half uses bit 15. req_signed=1 fills with the sign bit, else zeros.
- Write enables are decoded from the state register only. They are never asserted in IDLE or RESP, or while reset is high.
- Read addresses are driven even during stores; their values are don't-care.
- Latency from accept edge to resp_valid: byte/half 2 cycles; word 3 cycles; size-11 error 1 cycle.
- Throughput: one request per 3 (byte/half) or 4 (word) cycles with resp_ready=1.
- Reset mid-operation: the access is aborted. Bytes already written stay written; no further strobes; the response is dropped.
- resp_ready held low: the unit stalls in RESP indefinitely with outputs stable.

Optional Feature:
- Macro AAP_LSU_ALIGN_CHECK_EN.
- Defined: half with A[0]≠0, or word with A[1:0]≠0, skips BEAT0/BEAT1 and goes to RESP with resp_err=1 and resp_rdata=0. No write strobes.
- Undefined: misaligned accesses execute byte-wise with address wrap as above; resp_err only for size 11.

Test Plan:
- Store word 0xA1B2C3D4 at 0x010, then load word from 0x010 → bytes 0x010..0x013 = D4,C3,B2,A1; resp_rdata=0xA1B2C3D4, resp_valid 3 cycles after accept.
- Memory byte 0x020=0x85: load byte signed → 0xFFFFFF85; load byte unsigned → 0x00000085; both with 2-cycle latency.
- Store half 0x1234 at 0x1FF (ADDR_W=9, macro undefined) → byte 0x1FF=0x34, byte 0x000=0x12. With the macro defined → resp_err=1, no write enables asserted.
- req_size=11 store → resp_err=1 one cycle after accept; wr enables never asserted; memory unchanged.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0. Raise resp_ready → IDLE next cycle; the next request is accepted the cycle after.
- Assert reset during BEAT0 of a word store to 0x040 → bytes 0x040/0x041 written, 0x042/0x043 untouched; outputs at reset values; no response.

Source files
------------

// File: rtl/aap_load_store_unit.sv
// aap_load_store_unit: initiator side of the data-memory byte-port interface.
// Takes one 8/16/32-bit load/store from the execute stage over valid/ready and
// splits it into byte accesses, two bytes per beat, on two read and two write
// byte ports. Returns zero/sign-extended load data or store completion over a
// valid/ready response channel.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_write, req_size          1=store; 00 byte, 01 half, 10 word, 11 reserved
//   req_signed, req_addr         sign-extend loads; lowest byte address
//   req_wdata                    store data (low bytes for byte/half)
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         load data (0 for stores/errors); rejected request
//   mem_rd1/2, mem_rd1/2_out     byte read addresses and combinational read data
//   mem_wr1/2, mem_wr1/2_data    byte write addresses and data
//   mem_wr1/2_enable             write strobes, sampled on the clock edge
//
// Optional build macro AAP_LSU_ALIGN_CHECK_EN: misaligned half/word requests are
// rejected with resp_err=1 and make no memory access. Without it they execute
// byte-wise with address wrap.
module aap_load_store_unit #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_rd1,
    output logic [ADDR_W-1:0] mem_rd2,
    input  logic [7:0]        mem_rd1_out,
    input  logic [7:0]        mem_rd2_out,
    output logic [ADDR_W-1:0] mem_wr1,
    output logic [ADDR_W-1:0] mem_wr2,
    output logic [7:0]        mem_wr1_data,
    output logic [7:0]        mem_wr2_data,
    output logic              mem_wr1_enable,
    output logic              mem_wr2_enable
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                write_q;
    logic                signed_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0][7:0]     byte_q, byte_d;
    logic                accept;
    logic                err_next;
    logic                misaligned;
    logic [DATA_W-1:0]   load_data;

    // Alignment rejection exists only in the checked build.
`ifdef AAP_LSU_ALIGN_CHECK_EN
    assign misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and load-byte capture.
    always_comb begin
        next_state = state;
        byte_d     = byte_q;
        accept     = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if ((req_size == SIZE_RSVD) || misaligned) begin
                        next_state = RESP;
                        err_next   = 1'b1;
                    end else begin
                        next_state = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (!write_q) begin
                    byte_d[0] = mem_rd1_out;
                    byte_d[1] = mem_rd2_out;
                end
                next_state = (size_q == SIZE_WORD) ? BEAT1 : RESP;
            end
            BEAT1: begin
                if (!write_q) begin
                    byte_d[2] = mem_rd1_out;
                    byte_d[3] = mem_rd2_out;
                end
                next_state = RESP;
            end
            RESP: begin
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Little-endian assembly and extension from the bytes being captured this edge.
    always_comb begin
        load_data = '0;
        if (!write_q) begin
            case (size_q)
                SIZE_BYTE: load_data = {{24{signed_q & byte_d[0][7]}}, byte_d[0]};
                SIZE_HALF: load_data = {{16{signed_q & byte_d[1][7]}}, byte_d[1], byte_d[0]};
                default:   load_data = byte_d;
            endcase
        end
    end

    // Memory port decode; strobes depend only on registered state.
    always_comb begin
        mem_rd1        = '0;
        mem_rd2        = '0;
        mem_wr1        = '0;
        mem_wr2        = '0;
        mem_wr1_data   = '0;
        mem_wr2_data   = '0;
        mem_wr1_enable = 1'b0;
        mem_wr2_enable = 1'b0;
        case (state)
            BEAT0: begin
                mem_rd1        = addr_q;
                mem_rd2        = addr_q + ADDR_W'(1);
                mem_wr1        = addr_q;
                mem_wr2        = addr_q + ADDR_W'(1);
                mem_wr1_data   = wdata_q[7:0];
                mem_wr2_data   = wdata_q[15:8];
                mem_wr1_enable = write_q;
                mem_wr2_enable = write_q && (size_q != SIZE_BYTE);
            end
            BEAT1: begin
                mem_rd1        = addr_q + ADDR_W'(2);
                mem_rd2        = addr_q + ADDR_W'(3);
                mem_wr1        = addr_q + ADDR_W'(2);
                mem_wr2        = addr_q + ADDR_W'(3);
                mem_wr1_data   = wdata_q[23:16];
                mem_wr2_data   = wdata_q[31:24];
                mem_wr1_enable = write_q;
                mem_wr2_enable = write_q;
            end
            default: ;
        endcase
    end

    // State, request latch and registered response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            byte_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= next_state;
            byte_q     <= byte_d;
            req_ready  <= (next_state == IDLE);
            resp_valid <= (next_state == RESP);
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if ((next_state == RESP) && (state != RESP)) begin
                resp_err   <= err_next;
                resp_rdata <= err_next ? '0 : load_data;
            end else if ((next_state == IDLE) && (state == RESP)) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aap_load_store_unit.sv
// Bench for aap_load_store_unit: byte-array memory environment, directed steps
// followed by random requests checked against a byte-level reference model.
module tb_aap_load_store_unit;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned MEM_SIZE = 512;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_rd1, mem_rd2, mem_wr1, mem_wr2;
    logic [7:0]        mem_rd1_out, mem_rd2_out, mem_wr1_data, mem_wr2_data;
    logic              mem_wr1_enable, mem_wr2_enable;

    aap_load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd1(mem_rd1), .mem_rd2(mem_rd2),
        .mem_rd1_out(mem_rd1_out), .mem_rd2_out(mem_rd2_out),
        .mem_wr1(mem_wr1), .mem_wr2(mem_wr2),
        .mem_wr1_data(mem_wr1_data), .mem_wr2_data(mem_wr2_data),
        .mem_wr1_enable(mem_wr1_enable), .mem_wr2_enable(mem_wr2_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: combinational reads, strobed writes, one-shot image load.
    logic [7:0] mem      [MEM_SIZE];
    logic [7:0] init_img [MEM_SIZE];
    logic [7:0] ref_mem  [MEM_SIZE];
    logic       load_img;

    assign mem_rd1_out = mem[mem_rd1];
    assign mem_rd2_out = mem[mem_rd2];

    always @(posedge clock) begin
        if (load_img) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_img[i];
        end else begin
            if (mem_wr1_enable) mem[mem_wr1] <= mem_wr1_data;
            if (mem_wr2_enable) mem[mem_wr2] <= mem_wr2_data;
        end
    end

    // Strobe bookkeeping sampled mid-cycle.
    int wr_bytes;
    int viol;
    initial begin
        wr_bytes = 0;
        viol     = 0;
    end
    always @(negedge clock) begin
        wr_bytes <= wr_bytes + int'(mem_wr1_enable) + int'(mem_wr2_enable);
        if ((mem_wr1_enable || mem_wr2_enable) && (resp_valid || req_ready)) viol <= viol + 1;
    end

    int          checks;
    int          errors;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_addrs", 32'({mem_rd1, mem_rd2, mem_wr1}), 32'd0);
        check("rst_wr2_addr", 32'(mem_wr2), 32'd0);
        check("rst_wdata", 32'({mem_wr1_data, mem_wr2_data}), 32'd0);
        check("rst_wen", 32'({mem_wr1_enable, mem_wr2_enable}), 32'd0);
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [8:0] a);
        logic e;
        e = (sz == 2'b11);
`ifdef AAP_LSU_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0]) e = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
`else
        if (a == 9'h1FF && sz == 2'b11) e = 1'b1;
`endif
        return e;
    endfunction

    // One full transaction, called and returning at a falling edge.
    task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd, input int stall);
        int          n, exp_lat, lat, wr0;
        logic        exp_err;
        logic [31:0] exp_data, held;
        exp_err  = model_err(sz, a);
        n        = 1 << sz;
        exp_data = 32'd0;
        if (!exp_err && !wr) begin
            for (int i = 0; i < n; i++)
                exp_data |= 32'(ref_mem[(int'(a) + i) % MEM_SIZE]) << (8 * i);
            if (sg && n < 4 && exp_data[8*n-1])
                exp_data |= ~((32'h1 << (8 * n)) - 32'h1);
        end
        exp_lat = exp_err ? 1 : ((n == 4) ? 3 : 2);
        wr0     = wr_bytes;

        resp_ready = (stall == 0);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_rdata", resp_rdata, exp_data);
        held = resp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", resp_rdata, held);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
        check("wr_bytes", 32'(wr_bytes - wr0), (wr && !exp_err) ? 32'(n) : 32'd0);
        if (wr && !exp_err)
            for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MEM_SIZE] = wd[8*i +: 8];
        last_rdata = held;
    endtask

    initial begin
        int          wr0, seen, diff, r;
        logic [1:0]  sz;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        load_img   = 1'b0;

        for (int i = 0; i < MEM_SIZE; i++) init_img[i] = 8'($urandom);
        init_img[9'h020] = 8'h85;
        init_img[9'h040] = 8'h5A;
        init_img[9'h041] = 8'h5B;
        init_img[9'h042] = 8'h5C;
        init_img[9'h043] = 8'h5D;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_img[i];
        load_img = 1'b1;
        @(posedge clock);
        #1 load_img = 1'b0;

        @(negedge clock);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clock);

        // Word store then load, little-endian.
        xact(1'b1, 2'b10, 1'b0, 9'h010, 32'hA1B2C3D4, 0);
        check("word_bytes", {mem[9'h013], mem[9'h012], mem[9'h011], mem[9'h010]}, 32'hA1B2C3D4);
        xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 0);
        check("word_load", last_rdata, 32'hA1B2C3D4);

        // Byte load signed / unsigned.
        xact(1'b0, 2'b00, 1'b1, 9'h020, 32'd0, 0);
        check("lb_signed", last_rdata, 32'hFFFFFF85);
        xact(1'b0, 2'b00, 1'b0, 9'h020, 32'd0, 0);
        check("lb_unsigned", last_rdata, 32'h00000085);

        // Half store across the address wrap.
        xact(1'b1, 2'b01, 1'b0, 9'h1FF, 32'h00001234, 0);
`ifdef AAP_LSU_ALIGN_CHECK_EN
        check("half_wrap", 32'({mem[9'h1FF], mem[9'h000]}), 32'({init_img[9'h1FF], init_img[9'h000]}));
`else
        check("half_wrap", 32'({mem[9'h1FF], mem[9'h000]}), 32'h3412);
`endif

        // Reserved size rejected.
        xact(1'b1, 2'b11, 1'b0, 9'h080, 32'hDEADBEEF, 0);

        // Response back-pressure, then immediate follow-on request.
        xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 5);
        xact(1'b0, 2'b01, 1'b1, 9'h012, 32'd0, 0);
        check("half_signed", last_rdata, 32'hFFFFA1B2);

        // Reset after the first beat of a word store.
        wr0        = wr_bytes;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 9'h040;
        req_wdata  = 32'h11223344;
        req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_beat0_en", 32'({mem_wr1_enable, mem_wr2_enable}), 32'h3);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check_reset_vals();
        @(negedge clock);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) seen = 1;
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check("rst_bytes", {mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]}, 32'h5D5C3344);
        check("rst_wr_bytes", 32'(wr_bytes - wr0), 32'd2);
        ref_mem[9'h040] = 8'h44;
        ref_mem[9'h041] = 8'h33;

        // Random traffic against the reference model.
        for (int k = 0; k < 80; k++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, MEM_SIZE - 1)), $urandom,
                 ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        diff = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image", 32'(diff), 32'd0);
        check("strobe_idle_resp", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
